mem_stage: RTL

//  Memory-access stage of the 5-stage flow CPU. Sits between the ex_mem pipeline register and mem_wb.
//  Non-memory ops pass straight through.
//  LB/LBU/LH/LHU/LW/SB/SH/SW are run as one handshake on the data bus (big-endian byte lanes), with

---
 rtl/mem_stage_pkg.sv | 62 ++++++
 rtl/mem_lane_align.sv | 76 +++++++
 rtl/mem_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the memory-access stage: register/bus widths,
//   ALU op codes for the load/store group, FSM state encodings and a small
//   op decoder used by the lane-alignment logic.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int          REG_W      = 32;
  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG    = 5'd0;

  // Op codes as carried by ex_mem (legacy 8-bit encoding)
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  typedef struct packed {
    logic      is_mem;
    logic      is_store;
    logic      is_signed;
    acc_size_t size;
  } op_info_t;

  // Classify an op code into access kind, size and extension mode.
  function automatic op_info_t decode_op(input logic [7:0] op);
    op_info_t info;
    info = '{is_mem: 1'b0, is_store: 1'b0, is_signed: 1'b0, size: SZ_WORD};
    case (op)
      EXE_LB_OP:  info = '{is_mem: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: SZ_BYTE};
      EXE_LBU_OP: info = '{is_mem: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SZ_BYTE};
      EXE_LH_OP:  info = '{is_mem: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: SZ_HALF};
      EXE_LHU_OP: info = '{is_mem: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SZ_HALF};
      EXE_LW_OP:  info = '{is_mem: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SZ_WORD};
      EXE_SB_OP:  info = '{is_mem: 1'b1, is_store: 1'b1, is_signed: 1'b0, size: SZ_BYTE};
      EXE_SH_OP:  info = '{is_mem: 1'b1, is_store: 1'b1, is_signed: 1'b0, size: SZ_HALF};
      EXE_SW_OP:  info = '{is_mem: 1'b1, is_store: 1'b1, is_signed: 1'b0, size: SZ_WORD};
      default:    info = '{is_mem: 1'b0, is_store: 1'b0, is_signed: 1'b0, size: SZ_WORD};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
//   Combinational byte-lane logic for a big-endian 32-bit data bus.
//   Ports:
//     aluop      in   8   op code
//     addr_lo    in   2   low address bits (byte offset in word)
//     sdata      in   32  store data (rt value)
//     rdata      in   32  captured read word
//     is_mem     out  1   op is a load or store
//     is_store   out  1   op is a store
//     misaligned out  1   halfword at odd address / word not on 4-byte boundary
//     sel        out  4   byte-lane enables, bit3 = bits[31:24]
//     wdata      out  32  store data replicated across lanes
//     load_data  out  32  extracted and sign/zero-extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]       aluop,
  input  logic [1:0]       addr_lo,
  input  logic [REG_W-1:0] sdata,
  input  logic [REG_W-1:0] rdata,
  output logic             is_mem,
  output logic             is_store,
  output logic             misaligned,
  output logic [3:0]       sel,
  output logic [REG_W-1:0] wdata,
  output logic [REG_W-1:0] load_data
);

  op_info_t   info;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, store replication and load extraction per access size.
  always_comb begin
    info       = decode_op(aluop);
    is_mem     = info.is_mem;
    is_store   = info.is_store;
    misaligned = 1'b0;
    sel        = 4'b0000;
    wdata      = ZERO_WORD;
    load_data  = ZERO_WORD;
    // Offset 0 is the most significant byte, so invert the offset to get the bit base
    byte_v     = rdata[{~addr_lo, 3'b000} +: 8];
    half_v     = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    if (info.is_mem) begin
      case (info.size)
        SZ_BYTE: begin
          sel       = 4'b1000 >> addr_lo;
          wdata     = {4{sdata[7:0]}};
          load_data = info.is_signed ? {{24{byte_v[7]}}, byte_v} : {24'h00_0000, byte_v};
        end
        SZ_HALF: begin
          misaligned = addr_lo[0];
          sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
          wdata      = {2{sdata[15:0]}};
          load_data  = info.is_signed ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
        end
        SZ_WORD: begin
          misaligned = (addr_lo != 2'b00);
          sel        = 4'b1111;
          wdata      = sdata;
          load_data  = rdata;
        end
        default: begin
          misaligned = 1'b0;
          sel        = 4'b0000;
        end
      endcase
    end else begin
      misaligned = 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage between ex_mem and mem_wb. Non-memory ops pass
//   straight through; loads/stores run one req/ack handshake on the data bus
//   while stallreq freezes the pipeline. Misaligned accesses are flagged and
//   never reach the bus.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     mem_wd/wreg/wdata/aluop     instruction fields from ex_mem
//     mem_addr, mem_sdata         effective address and store data
//     wb_wd/wreg/wdata            result towards mem_wb
//     stallreq, misalign          stall request to ctrl, address-error flag
//     dbus_req/we/sel/addr/wdata  registered data-bus request
//     dbus_ack, dbus_rdata        bus completion pulse and read word
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [7:0]        mem_aluop,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_sdata,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              stallreq,
  output logic              misalign,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [3:0]        dbus_sel,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_ack,
  input  logic [DATA_W-1:0] dbus_rdata
);

  logic [1:0]        state;
  logic              req_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              is_mem;
  logic              is_store;
  logic              misaligned;
  logic [3:0]        lane_sel;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] load_data;

  mem_lane_align u_align (
    .aluop      (mem_aluop),
    .addr_lo    (mem_addr[1:0]),
    .sdata      (mem_sdata),
    .rdata      (rdata_q),
    .is_mem     (is_mem),
    .is_store   (is_store),
    .misaligned (misaligned),
    .sel        (lane_sel),
    .wdata      (lane_wdata),
    .load_data  (load_data)
  );

  // Access FSM, bus request registers and captured read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mem && !misaligned) begin
            req_q   <= 1'b1;
            we_q    <= is_store;
            sel_q   <= lane_sel;
            addr_q  <= {mem_addr[ADDR_W-1:2], 2'b00};
            wdata_q <= lane_wdata;
            state   <= ST_WAIT;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // Request fields stay untouched until the slave acknowledges
          if (dbus_ack) begin
            req_q   <= 1'b0;
            rdata_q <= dbus_rdata;
            state   <= ST_DONE;
          end else begin
            state   <= ST_WAIT;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          req_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Writeback / stall / misalign muxing; everything forced low during reset.
  always_comb begin
    wb_wd    = mem_wd;
    wb_wreg  = 1'b0;
    wb_wdata = '0;
    stallreq = 1'b0;
    misalign = 1'b0;
    if (rst) begin
      wb_wd = NOP_REG;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!is_mem) begin
            wb_wreg  = mem_wreg;
            wb_wdata = mem_wdata;
          end else if (misaligned) begin
            misalign = 1'b1;
          end else begin
            stallreq = 1'b1;
          end
        end
        ST_WAIT: begin
          stallreq = 1'b1;
        end
        ST_DONE: begin
          if (!is_store) begin
            wb_wreg  = mem_wreg;
            wb_wdata = load_data;
          end else begin
            wb_wreg  = 1'b0;
          end
        end
        default: begin
          stallreq = 1'b0;
        end
      endcase
    end
  end

  // Bus outputs are the request registers, held at zero while reset is asserted.
  always_comb begin
    if (rst) begin
      dbus_req   = 1'b0;
      dbus_we    = 1'b0;
      dbus_sel   = 4'b0000;
      dbus_addr  = '0;
      dbus_wdata = '0;
    end else begin
      dbus_req   = req_q;
      dbus_we    = we_q;
      dbus_sel   = sel_q;
      dbus_addr  = addr_q;
      dbus_wdata = wdata_q;
    end
  end

endmodule
